// File: rtl/bot_issue_feeder_if.sv
// Bot issue feeder bus: upstream bot stream in, registered bot issue out to
// the pipeline, plus the downstream FIFO fullness used for back-pressure.
interface bot_issue_feeder_if #(
  parameter int ADDR_WIDTH = 9
);
  // Upstream stream
  logic [127:0]          inBot;
  logic [5:0]            inValidPermutations;
  logic                  inLast;
  logic                  inValid;
  logic                  inReady;
  // Downstream pipeline
  logic [4:0]            fifoFullness;
  logic [127:0]          bot;
  logic [ADDR_WIDTH-1:0] botIndex;
  logic                  isBotValid;
  logic [5:0]            validBotPermutations;

  // Feeder side
  modport master (
    input  inBot, inValidPermutations, inLast, inValid, fifoFullness,
    output inReady, bot, botIndex, isBotValid, validBotPermutations
  );

  // Environment side (upstream source and downstream pipeline)
  modport slave (
    output inBot, inValidPermutations, inLast, inValid, fifoFullness,
    input  inReady, bot, botIndex, isBotValid, validBotPermutations
  );
endinterface

// File: rtl/bot_issue_feeder.sv
// Bot issue feeder: accepts bots from upstream while the pipeline input FIFO
// has room, tags each with a wrapping index, issues it one cycle later, then
// waits a fixed drain period after the last bot before pulsing done.
module bot_issue_feeder #(
  parameter int ADDR_WIDTH     = 9,
  parameter int FULL_THRESHOLD = 20,
  parameter int DRAIN_CYCLES   = 64
) (
  input  logic                    clk,
  input  logic                    rst,          // synchronous, active-low
  input  logic                    start,
  bot_issue_feeder_if.master      bus,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             issuedCount
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                stateReg;
  state_t                stateNext;

  logic [127:0]          botReg;
  logic [5:0]            permReg;
  logic [ADDR_WIDTH-1:0] botIndexReg;
  logic                  isBotValidReg;
  logic [ADDR_WIDTH-1:0] indexReg;
  logic [31:0]           issuedCountReg;
  logic [DRAIN_W-1:0]    drainReg;

  logic                  inReadyInt;
  logic                  roomAvailable;
  logic                  xfer;

  // The margin below a full FIFO absorbs the downstream input pipe and the
  // lag in the reported fullness, so the stall compare is strict.
  assign roomAvailable = (32'(bus.fifoFullness) < 32'(FULL_THRESHOLD));
  assign xfer          = bus.inValid & inReadyInt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic: start only counts in IDLE, last accepted bot opens drain
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (xfer && bus.inLast) stateNext = DRAIN;
      DRAIN:   if (drainReg <= DRAIN_W'(1)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic: ready is held low while reset is asserted so a transfer
  // coinciding with reset is never accepted
  always_comb begin
    inReadyInt = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (stateReg)
      RUN: begin
        inReadyInt = rst & roomAvailable;
        busy       = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Issue datapath, index/issue counters and drain countdown
  always_ff @(posedge clk) begin
    if (!rst) begin
      botReg         <= '0;
      permReg        <= '0;
      botIndexReg    <= '0;
      isBotValidReg  <= 1'b0;
      indexReg       <= '0;
      issuedCountReg <= '0;
      drainReg       <= '0;
    end else begin
      isBotValidReg <= xfer;
      if (xfer) begin
        botReg      <= bus.inBot;
        permReg     <= bus.inValidPermutations;
        botIndexReg <= indexReg;
        // Index wraps silently; an empty permutation mask still uses a slot
        indexReg    <= indexReg + 1'b1;
        if (issuedCountReg != 32'hFFFF_FFFF) begin
          issuedCountReg <= issuedCountReg + 32'd1;
        end
      end
      if (stateReg == IDLE && start) begin
        indexReg       <= '0;
        issuedCountReg <= '0;
      end
      if (xfer && bus.inLast) begin
        drainReg <= DRAIN_LOAD;
      end else if (stateReg == DRAIN && drainReg != '0) begin
        drainReg <= drainReg - 1'b1;
      end
    end
  end

  assign bus.inReady              = inReadyInt;
  assign bus.bot                  = botReg;
  assign bus.botIndex             = botIndexReg;
  assign bus.isBotValid           = isBotValidReg;
  assign bus.validBotPermutations = permReg;
  assign issuedCount              = issuedCountReg;

endmodule
